alarm_controller: RTL

Sequences the alarm clock's alarm behaviour around the time comparator. Holds the user's alarm time and drives the comparator's compare time, which is the alarm time or a snoozed time. Detects the comparator's match pulse and runs the ring / snooze / dismiss state machine. Drives the buzzer enable and snooze indicator for the display/sound logic.

---
 rtl/alarm_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alarm_controller.sv
// Alarm sequencer around the time comparator: alarm time storage, snooze arithmetic,
// and the ring/snooze/dismiss FSM. Optional ring auto-silence under ALARM_TIMEOUT_EN.
module alarm_controller #(
   parameter int SNOOZE_MIN     = 9,
   parameter int MAX_SNOOZE     = 3,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sec_tick,
   input  logic        alarm_en,
   input  logic        set_alarm,
   input  logic [15:0] alarm_set_time,
   input  logic        sound_alarm,
   input  logic        snooze_btn,
   input  logic        dismiss_btn,
   output logic [15:0] compare_time,
   output logic        alarm_on,
   output logic        snooze_active,
   output logic        set_err
);

   typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

   state_t      state_q, state_d;
   logic [15:0] alarm_reg_q, alarm_reg_d;
   logic [15:0] compare_time_q, compare_time_d;
   logic [3:0]  snooze_cnt_q, snooze_cnt_d;
   logic        alarm_on_q, alarm_on_d;
   logic        snooze_active_q, snooze_active_d;
   logic        set_err_q, set_err_d;
   logic        sound_q, snooze_btn_q, dismiss_btn_q;
   logic        sound_rise, snooze_rise, dismiss_rise;
   logic        set_ok;

`ifdef ALARM_TIMEOUT_EN
   logic [7:0]  sec_cnt_q, sec_cnt_d;
   logic [7:0]  sec_inc;
   assign sec_inc = sec_cnt_q + 8'd1;
`else
   logic        unused_sec_tick;
   localparam int unused_ring_timeout = RING_TIMEOUT_S;
   assign unused_sec_tick = sec_tick;
`endif

   // Operands are always valid BCD, so a binary round trip keeps the result valid BCD.
   function automatic logic [15:0] add_snooze(input logic [15:0] t);
      logic [6:0] mins;
      logic [6:0] hrs;
      mins = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(SNOOZE_MIN);
      hrs  = 7'(t[15:12]) * 7'd10 + 7'(t[11:8]);
      if (mins >= 7'd60) begin
         mins = mins - 7'd60;
         hrs  = hrs + 7'd1;
      end
      if (hrs >= 7'd24) hrs = hrs - 7'd24;
      return {4'(hrs / 7'd10), 4'(hrs % 7'd10), 4'(mins / 7'd10), 4'(mins % 7'd10)};
   endfunction

   assign sound_rise   = sound_alarm & ~sound_q;
   assign snooze_rise  = snooze_btn & ~snooze_btn_q;
   assign dismiss_rise = dismiss_btn & ~dismiss_btn_q;

   assign set_ok = (alarm_set_time[15:12] <= 4'd2) && (alarm_set_time[11:8] <= 4'd9) &&
                   !((alarm_set_time[15:12] == 4'd2) && (alarm_set_time[11:8] > 4'd3)) &&
                   (alarm_set_time[7:4] <= 4'd5) && (alarm_set_time[3:0] <= 4'd9);

   always_comb begin
      state_d        = state_q;
      alarm_reg_d    = alarm_reg_q;
      compare_time_d = compare_time_q;
      snooze_cnt_d   = snooze_cnt_q;
      alarm_on_d     = alarm_on_q;
      set_err_d      = set_alarm && !set_ok;
`ifdef ALARM_TIMEOUT_EN
      sec_cnt_d      = sec_cnt_q;
`endif
      if (set_alarm && set_ok) alarm_reg_d = alarm_set_time;

      if (!alarm_en) begin
         state_d        = IDLE;
         alarm_on_d     = 1'b0;
         snooze_cnt_d   = 4'd0;
         compare_time_d = alarm_reg_d;
      end else if (set_alarm && set_ok) begin
         state_d        = ARMED;
         compare_time_d = alarm_set_time;
         snooze_cnt_d   = 4'd0;
         alarm_on_d     = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               if (sound_rise) begin
                  state_d    = RINGING;
                  alarm_on_d = 1'b1;
`ifdef ALARM_TIMEOUT_EN
                  sec_cnt_d  = 8'd0;
`endif
               end
            end
            RINGING: begin
               if (dismiss_rise) begin
                  state_d        = ARMED;
                  compare_time_d = alarm_reg_q;
                  snooze_cnt_d   = 4'd0;
                  alarm_on_d     = 1'b0;
               end else if (snooze_rise && (snooze_cnt_q < 4'(MAX_SNOOZE))) begin
                  state_d        = SNOOZE;
                  compare_time_d = add_snooze(compare_time_q);
                  snooze_cnt_d   = snooze_cnt_q + 4'd1;
                  alarm_on_d     = 1'b0;
               end
`ifdef ALARM_TIMEOUT_EN
               else if (sec_tick) begin
                  if (sec_inc >= 8'(RING_TIMEOUT_S)) begin
                     state_d        = ARMED;
                     compare_time_d = alarm_reg_q;
                     snooze_cnt_d   = 4'd0;
                     alarm_on_d     = 1'b0;
                  end else begin
                     sec_cnt_d = sec_inc;
                  end
               end
`endif
            end
            SNOOZE: begin
               if (dismiss_rise) begin
                  state_d        = ARMED;
                  compare_time_d = alarm_reg_q;
                  snooze_cnt_d   = 4'd0;
                  alarm_on_d     = 1'b0;
               end else if (sound_rise) begin
                  state_d    = RINGING;
                  alarm_on_d = 1'b1;
`ifdef ALARM_TIMEOUT_EN
                  sec_cnt_d  = 8'd0;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
      snooze_active_d = (state_d == SNOOZE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         alarm_reg_q     <= 16'h0000;
         compare_time_q  <= 16'h0000;
         snooze_cnt_q    <= 4'd0;
         alarm_on_q      <= 1'b0;
         snooze_active_q <= 1'b0;
         set_err_q       <= 1'b0;
         sound_q         <= 1'b0;
         snooze_btn_q    <= 1'b0;
         dismiss_btn_q   <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
         sec_cnt_q       <= 8'd0;
`endif
      end else begin
         state_q         <= state_d;
         alarm_reg_q     <= alarm_reg_d;
         compare_time_q  <= compare_time_d;
         snooze_cnt_q    <= snooze_cnt_d;
         alarm_on_q      <= alarm_on_d;
         snooze_active_q <= snooze_active_d;
         set_err_q       <= set_err_d;
         sound_q         <= sound_alarm;
         snooze_btn_q    <= snooze_btn;
         dismiss_btn_q   <= dismiss_btn;
`ifdef ALARM_TIMEOUT_EN
         sec_cnt_q       <= sec_cnt_d;
`endif
      end
   end

   assign compare_time  = compare_time_q;
   assign alarm_on      = alarm_on_q;
   assign snooze_active = snooze_active_q;
   assign set_err       = set_err_q;

endmodule
